// File: rtl/iptx_arbiter.sv
// iptx_arbiter
//   Frame-level round-robin arbiter that shares the single IP transmit
//   datapath between two packet sources. A source is granted for a whole
//   frame (sof..eof). After every frame or abort, IFG idle cycles pass
//   before the next arbitration. A frame is aborted if its source stalls
//   for TIMEOUT cycles while the downstream is ready, or if the source
//   restarts with a new sof in the middle of a frame.
//
// Handshake: a beat moves on a source port when validin & ready are both
//   high at a rising clock edge. A source holds its beat stable until it is
//   accepted. Downstream takes every beat with outvalid=1; outready only
//   says whether a beat may be offered in this cycle.
//
// Ports
//   clock, reset             clock; synchronous active-low reset
//   s0*/s1*                  validin, sof, eof, datain in; ready out
//   outready                 downstream may take a beat this cycle
//   outvalid/outsof/outeof/outdata  forwarded beat (zero latency)
//   outabort                 one-cycle pulse: current frame is truncated
//   outsel                   source currently or last granted
//   busy                     a frame is being forwarded
//   framecnt                 completed frames, wraps
//   dropcnt                  discarded beats, saturates at 255
module iptx_arbiter #(
  parameter int DW      = 16,
  parameter int IFG     = 2,
  parameter int TIMEOUT = 255
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          s0validin,
  input  logic          s0sof,
  input  logic          s0eof,
  input  logic [DW-1:0] s0datain,
  output logic          s0ready,
  input  logic          s1validin,
  input  logic          s1sof,
  input  logic          s1eof,
  input  logic [DW-1:0] s1datain,
  output logic          s1ready,
  input  logic          outready,
  output logic          outvalid,
  output logic          outsof,
  output logic          outeof,
  output logic [DW-1:0] outdata,
  output logic          outabort,
  output logic          outsel,
  output logic          busy,
  output logic [15:0]   framecnt,
  output logic [7:0]    dropcnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          grant;      // source that owns the datapath
  logic          prio;       // source that wins the next tie
  logic          started;    // sof of the current frame has been forwarded
  logic [7:0]    stall_cnt;
  logic [15:0]   gap_cnt;
  logic [1:0]    drain;      // discard the rest of an aborted frame

  logic          in_busy;
  logic          g_valid, g_sof, g_eof;
  logic [DW-1:0] g_data;
  logic          fwd_ready, xfer, frame_end, restart, stall, timeout, abort;
  logic [1:0]    req, discard;
  logic          gnt_nxt;
  logic [8:0]    drop_sum;

  assign in_busy = (state == ST_BUSY);
  assign g_valid = grant ? s1validin : s0validin;
  assign g_sof   = grant ? s1sof     : s0sof;
  assign g_eof   = grant ? s1eof     : s0eof;
  assign g_data  = grant ? s1datain  : s0datain;

  // A second sof inside a frame is not accepted; it aborts the frame and
  // waits to be arbitrated again.
  assign fwd_ready = in_busy & outready & ~(g_sof & started);
  assign xfer      = g_valid & fwd_ready;
  assign frame_end = xfer & g_eof;
  assign restart   = in_busy & g_valid & g_sof & started;
  assign stall     = in_busy & outready & ~g_valid;
  assign timeout   = stall & (stall_cnt == 8'(TIMEOUT - 1));
  assign abort     = restart | timeout;

  assign req     = {s1validin & s1sof, s0validin & s0sof};
  assign gnt_nxt = (req == 2'b11) ? prio : req[1];

  // Non-sof beats are swallowed whenever no frame is open for them: always
  // outside BUSY, and in BUSY only for the other source when it is draining.
  assign discard[0] = s0validin & ~s0sof & (in_busy ? (grant & drain[0]) : 1'b1);
  assign discard[1] = s1validin & ~s1sof & (in_busy ? (~grant & drain[1]) : 1'b1);

  assign drop_sum = {1'b0, dropcnt} + {8'd0, discard[0]} + {8'd0, discard[1]};

  // State register
  always_ff @(posedge clock) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (|req) state_nxt = ST_BUSY;
      ST_BUSY: if (frame_end || abort) state_nxt = (IFG == 0) ? ST_IDLE : ST_GAP;
      ST_GAP:  if (gap_cnt == 16'(IFG - 1)) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    s0ready  = (~grant & fwd_ready) | discard[0];
    s1ready  = ( grant & fwd_ready) | discard[1];
    outvalid = xfer;
    outsof   = xfer & g_sof;
    outeof   = xfer & g_eof;
    outdata  = xfer ? g_data : '0;
    busy     = in_busy;
    outsel   = grant;
  end

  // Grant, counters and flags
  always_ff @(posedge clock) begin
    if (!reset) begin
      grant     <= 1'b0;
      prio      <= 1'b0;
      started   <= 1'b0;
      stall_cnt <= '0;
      gap_cnt   <= '0;
      drain     <= '0;
      framecnt  <= '0;
      dropcnt   <= '0;
      outabort  <= 1'b0;
    end else begin
      if (state == ST_IDLE && |req) begin
        grant <= gnt_nxt;
        prio  <= ~gnt_nxt;
      end

      if (frame_end || abort)  started <= 1'b0;
      else if (xfer && g_sof)  started <= 1'b1;

      // outready=0 leaves the count frozen
      if (!in_busy || xfer || abort) stall_cnt <= '0;
      else if (stall)                stall_cnt <= stall_cnt + 8'd1;

      if (state == ST_GAP && state_nxt == ST_GAP) gap_cnt <= gap_cnt + 16'd1;
      else                                        gap_cnt <= '0;

      outabort <= abort;

      if (frame_end) framecnt <= framecnt + 16'd1;

      if (timeout && !grant)                                drain[0] <= 1'b1;
      else if ((s0validin && s0sof) || (discard[0] && s0eof)) drain[0] <= 1'b0;

      if (timeout && grant)                                 drain[1] <= 1'b1;
      else if ((s1validin && s1sof) || (discard[1] && s1eof)) drain[1] <= 1'b0;

      dropcnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

endmodule

// File: tb/tb_iptx_arbiter.sv
// Testbench for iptx_arbiter: directed scenarios plus a randomized run with
// random backpressure. Expected beats are queued per source when a frame is
// issued; a monitor pops and compares every forwarded beat.
module tb_iptx_arbiter;
  localparam int DW      = 16;
  localparam int IFG     = 2;
  localparam int TIMEOUT = 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  initial forever #5 clock = ~clock;

  int cyc = 0;
  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // ---------------- DUT ----------------
  logic          src_v   [2];
  logic          src_sof [2];
  logic          src_eof [2];
  logic [DW-1:0] src_d   [2];
  logic          s0ready, s1ready;
  logic          outready;
  logic          outvalid, outsof, outeof, outabort, outsel, busy;
  logic [DW-1:0] outdata;
  logic [15:0]   framecnt;
  logic [7:0]    dropcnt;
  logic          rand_ready = 1'b0;

  iptx_arbiter #(.DW(DW), .IFG(IFG), .TIMEOUT(TIMEOUT)) dut (
    .clock     (clock),
    .reset     (reset),
    .s0validin (src_v[0]),
    .s0sof     (src_sof[0]),
    .s0eof     (src_eof[0]),
    .s0datain  (src_d[0]),
    .s0ready   (s0ready),
    .s1validin (src_v[1]),
    .s1sof     (src_sof[1]),
    .s1eof     (src_eof[1]),
    .s1datain  (src_d[1]),
    .s1ready   (s1ready),
    .outready  (outready),
    .outvalid  (outvalid),
    .outsof    (outsof),
    .outeof    (outeof),
    .outdata   (outdata),
    .outabort  (outabort),
    .outsel    (outsel),
    .busy      (busy),
    .framecnt  (framecnt),
    .dropcnt   (dropcnt)
  );

  // ---------------- scoreboard state ----------------
  logic [DW+1:0] exp_q0[$];
  logic [DW+1:0] exp_q1[$];
  int sof_sel_q[$];
  int sof_cyc_q[$];
  int eof_cyc_q[$];
  int beats_seen  = 0;
  int aborts_seen = 0;
  int abort_cyc   = 0;
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // ---------------- driver tasks ----------------
  task automatic put(input int s, input logic v, input logic sf, input logic ef,
                     input logic [DW-1:0] d);
    src_v[s] = v; src_sof[s] = sf; src_eof[s] = ef; src_d[s] = d;
  endtask

  function automatic logic rdy(input int s);
    return (s == 1) ? s1ready : s0ready;
  endfunction

  task automatic push_exp(input int s, input logic sf, input logic ef, input logic [DW-1:0] d);
    if (s == 0) exp_q0.push_back({sf, ef, d});
    else        exp_q1.push_back({sf, ef, d});
  endtask

  // Present one beat and hold it until accepted; returns at posedge+1.
  task automatic send_beat(input int s, input logic sf, input logic ef, input logic [DW-1:0] d);
    int n;
    n = 0;
    put(s, 1'b1, sf, ef, d);
    @(negedge clock);
    while (!rdy(s) && n < 1000) begin
      n++;
      @(negedge clock);
    end
    if (n >= 1000) bound_fail($sformatf("handshake_s%0d", s));
    @(posedge clock); #1;
    put(s, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic idle_cycles(input int k);
    repeat (k) begin
      @(posedge clock); #1;
    end
  endtask

  // Random-data frame; expected beats are queued as the frame is issued.
  task automatic send_frame(input int s, input int len, input int gmax, input int pre);
    logic [DW-1:0] d;
    logic sf, ef;
    idle_cycles(pre);
    for (int i = 0; i < len; i++) begin
      d  = DW'($urandom);
      sf = (i == 0);
      ef = (i == len - 1);
      push_exp(s, sf, ef, d);
      if (i > 0) idle_cycles($urandom_range(0, gmax));
      send_beat(s, sf, ef, d);
    end
  endtask

  task automatic do_reset();
    rand_ready = 1'b0;
    outready   = 1'b1;
    put(0, 1'b0, 1'b0, 1'b0, '0);
    put(1, 1'b0, 1'b0, 1'b0, '0);
    reset = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    exp_q0.delete();
    exp_q1.delete();
    sof_sel_q.delete();
    sof_cyc_q.delete();
    eof_cyc_q.delete();
    beats_seen  = 0;
    aborts_seen = 0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0 || busy) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 2000) bound_fail("drain");
    repeat (IFG + 2) @(negedge clock);
  endtask

  // ---------------- random backpressure ----------------
  initial forever begin
    @(posedge clock); #1;
    if (rand_ready) outready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    logic [DW+1:0] got;
    if (reset) begin
      if (outabort) begin
        aborts_seen++;
        abort_cyc = cyc;
        check("abort_no_valid", {31'd0, outvalid}, 32'd0);
      end
      if (outvalid) begin
        got = {outsof, outeof, outdata};
        beats_seen++;
        if (outsof) begin
          sof_sel_q.push_back(int'(outsel));
          sof_cyc_q.push_back(cyc);
        end
        if (outeof) eof_cyc_q.push_back(cyc);
        if (outsel == 1'b0 && exp_q0.size() != 0)      check("beat_s0", 32'(got), 32'(exp_q0.pop_front()));
        else if (outsel == 1'b1 && exp_q1.size() != 0) check("beat_s1", 32'(got), 32'(exp_q1.pop_front()));
        else begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got sel=%0d data 0x%0h with nothing expected", outsel, got);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int fcnt;
    do_reset();

    // Reset values
    @(negedge clock);
    check("rst_outvalid", {31'd0, outvalid}, 32'd0);
    check("rst_busy",     {31'd0, busy},     32'd0);
    check("rst_outsel",   {31'd0, outsel},   32'd0);
    check("rst_outabort", {31'd0, outabort}, 32'd0);
    check("rst_framecnt", {16'd0, framecnt}, 32'd0);
    check("rst_dropcnt",  {24'd0, dropcnt},  32'd0);
    check("rst_s0ready",  {31'd0, s0ready},  32'd0);
    check("rst_outdata",  {16'd0, outdata},  32'd0);

    // ---- single frame, exact latency ----
    @(posedge clock); #1;
    push_exp(0, 1'b1, 1'b0, 16'h4500);
    push_exp(0, 1'b0, 1'b0, 16'h1234);
    push_exp(0, 1'b0, 1'b1, 16'hBEEF);
    put(0, 1'b1, 1'b1, 1'b0, 16'h4500);
    @(negedge clock);
    check("t1_req_ready", {31'd0, s0ready},  32'd0);
    check("t1_req_valid", {31'd0, outvalid}, 32'd0);
    @(negedge clock);
    check("t1_b0_valid", {31'd0, outvalid}, 32'd1);
    check("t1_b0_sof",   {31'd0, outsof},   32'd1);
    check("t1_b0_data",  {16'd0, outdata},  32'h4500);
    @(posedge clock); #1;
    put(0, 1'b1, 1'b0, 1'b0, 16'h1234);
    @(negedge clock);
    check("t1_b1_data", {16'd0, outdata}, 32'h1234);
    check("t1_b1_sof",  {31'd0, outsof},  32'd0);
    @(posedge clock); #1;
    put(0, 1'b1, 1'b0, 1'b1, 16'hBEEF);
    @(negedge clock);
    check("t1_b2_data", {16'd0, outdata}, 32'hBEEF);
    check("t1_b2_eof",  {31'd0, outeof},  32'd1);
    @(posedge clock); #1;
    put(0, 1'b0, 1'b0, 1'b0, '0);
    @(negedge clock);
    check("t1_busy_after", {31'd0, busy},     32'd0);
    check("t1_framecnt",   {16'd0, framecnt}, 32'd1);

    // ---- tie, round robin and inter-frame gap ----
    do_reset();
    fork
      send_frame(0, 4, 0, 0);
      send_frame(1, 4, 0, 0);
    join
    fork
      send_frame(0, 4, 0, 0);
      send_frame(1, 4, 0, 0);
    join
    wait_drain();
    check("tie_sof_count", sof_sel_q.size(), 32'd4);
    if (sof_sel_q.size() == 4 && eof_cyc_q.size() >= 1) begin
      check("tie_order0", sof_sel_q[0], 32'd0);
      check("tie_order1", sof_sel_q[1], 32'd1);
      check("tie_order2", sof_sel_q[2], 32'd0);
      check("tie_order3", sof_sel_q[3], 32'd1);
      check("tie_gap", sof_cyc_q[1] - eof_cyc_q[0], IFG + 2);
    end
    check("tie_framecnt", {16'd0, framecnt}, 32'd4);

    // ---- backpressure mid-frame ----
    do_reset();
    fork
      send_frame(0, 6, 0, 0);
      begin
        int n;
        n = 0;
        while (beats_seen < 2 && n < 100) begin
          @(negedge clock);
          n++;
        end
        if (n >= 100) bound_fail("bp_start");
        @(posedge clock); #1;
        outready = 1'b0;
        repeat (5) begin
          @(negedge clock);
          check("bp_s0ready",  {31'd0, s0ready},  32'd0);
          check("bp_outvalid", {31'd0, outvalid}, 32'd0);
        end
        @(posedge clock); #1;
        outready = 1'b1;
      end
    join
    wait_drain();
    check("bp_aborts",   aborts_seen, 32'd0);
    check("bp_framecnt", {16'd0, framecnt}, 32'd1);

    // ---- stall timeout and drain ----
    do_reset();
    push_exp(0, 1'b1, 1'b0, 16'h0A0A);
    send_beat(0, 1'b1, 1'b0, 16'h0A0A);
    begin
      int n;
      n = 0;
      while (aborts_seen == 0 && n < 30) begin
        @(negedge clock);
        n++;
      end
    end
    check("to_aborts", aborts_seen, 32'd1);
    if (sof_cyc_q.size() == 1) check("to_latency", abort_cyc - sof_cyc_q[0], TIMEOUT + 1);
    @(posedge clock); #1;
    send_beat(0, 1'b0, 1'b0, 16'h1111);
    send_beat(0, 1'b0, 1'b1, 16'h2222);
    @(negedge clock);
    check("to_dropcnt",  {24'd0, dropcnt},  32'd2);
    check("to_framecnt", {16'd0, framecnt}, 32'd0);

    // ---- restart mid-frame ----
    do_reset();
    push_exp(1, 1'b1, 1'b0, 16'hA001);
    push_exp(1, 1'b0, 1'b0, 16'hA002);
    push_exp(1, 1'b1, 1'b0, 16'hB001);
    push_exp(1, 1'b0, 1'b0, 16'hB002);
    push_exp(1, 1'b0, 1'b1, 16'hB003);
    send_beat(1, 1'b1, 1'b0, 16'hA001);
    send_beat(1, 1'b0, 1'b0, 16'hA002);
    send_beat(1, 1'b1, 1'b0, 16'hB001);
    send_beat(1, 1'b0, 1'b0, 16'hB002);
    send_beat(1, 1'b0, 1'b1, 16'hB003);
    wait_drain();
    check("rs_aborts",   aborts_seen, 32'd1);
    check("rs_framecnt", {16'd0, framecnt}, 32'd1);
    check("rs_dropcnt",  {24'd0, dropcnt},  32'd0);

    // ---- reset mid-frame, stray beats, drop saturation ----
    do_reset();
    push_exp(0, 1'b1, 1'b0, 16'hC001);
    push_exp(0, 1'b0, 1'b0, 16'hC002);
    send_beat(0, 1'b1, 1'b0, 16'hC001);
    send_beat(0, 1'b0, 1'b0, 16'hC002);
    put(0, 1'b1, 1'b0, 1'b0, 16'hC003);
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    put(0, 1'b0, 1'b0, 1'b0, '0);
    @(negedge clock);
    check("mr_outvalid", {31'd0, outvalid}, 32'd0);
    check("mr_busy",     {31'd0, busy},     32'd0);
    check("mr_outabort", {31'd0, outabort}, 32'd0);
    check("mr_framecnt", {16'd0, framecnt}, 32'd0);
    check("mr_dropcnt",  {24'd0, dropcnt},  32'd0);
    check("mr_exp_left", exp_q0.size(), 32'd0);
    @(posedge clock); #1;
    put(0, 1'b1, 1'b0, 1'b0, 16'h5555);
    @(negedge clock);
    check("stray_ready", {31'd0, s0ready},  32'd1);
    check("stray_valid", {31'd0, outvalid}, 32'd0);
    @(posedge clock); #1;
    put(0, 1'b0, 1'b0, 1'b0, '0);
    @(negedge clock);
    check("stray_dropcnt", {24'd0, dropcnt}, 32'd1);
    check("mr_no_abort",   aborts_seen, 32'd0);
    @(posedge clock); #1;
    put(0, 1'b1, 1'b0, 1'b0, 16'h6666);
    idle_cycles(260);
    put(0, 1'b0, 1'b0, 1'b0, '0);
    @(negedge clock);
    check("drop_saturate", {24'd0, dropcnt}, 32'd255);

    // ---- randomized traffic with random backpressure ----
    do_reset();
    fcnt = 12;
    rand_ready = 1'b1;
    fork
      for (int i = 0; i < fcnt; i++) send_frame(0, $urandom_range(1, 6), 2, $urandom_range(0, 3));
      for (int j = 0; j < fcnt; j++) send_frame(1, $urandom_range(1, 6), 2, $urandom_range(0, 3));
    join
    rand_ready = 1'b0;
    @(posedge clock); #1;
    outready = 1'b1;
    wait_drain();
    check("rnd_framecnt", {16'd0, framecnt}, 2 * fcnt);
    check("rnd_dropcnt",  {24'd0, dropcnt},  32'd0);
    check("rnd_aborts",   aborts_seen, 32'd0);
    check("rnd_exp0_left", exp_q0.size(), 32'd0);
    check("rnd_exp1_left", exp_q1.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
